// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction-fetch, data-access and unified memory port signals.
// The arbiter takes the slave view; requesters plus the RAM take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic [STRB_W-1:0] data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_en;
  logic [STRB_W-1:0] mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output mem_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  mem_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between inst fetch and data access: data wins,
// except inst wins after losing MAX_WAIT consecutive contended cycles. Read data 1 cycle after grant.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic              inst_pend;
  logic              data_pend;
  logic              starved;
  logic              inst_gnt;
  logic              data_gnt;
  logic              data_rd;
  logic [ADDR_W-1:0] mux_addr;
  logic [STRB_W-1:0] mux_wen;
  logic [DATA_W-1:0] mux_wdata;

  assign starved = (starve_cnt == CNT_MAX);

  // Grants are gated by resetn so nothing reaches the RAM while reset is held.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      if (bus.data_req && !(bus.inst_req && starved)) begin
        data_gnt = 1'b1;
      end else if (bus.inst_req) begin
        inst_gnt = 1'b1;
      end
    end
  end

  assign data_rd = data_gnt && (bus.data_wen == '0);

  always_comb begin
    mux_addr  = '0;
    mux_wen   = '0;
    mux_wdata = '0;
    if (data_gnt) begin
      mux_addr  = bus.data_addr;
      mux_wen   = bus.data_wen;
      mux_wdata = bus.data_wdata;
    end else if (inst_gnt) begin
      mux_addr  = bus.inst_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
      inst_pend  <= 1'b0;
      data_pend  <= 1'b0;
    end else begin
      inst_pend <= inst_gnt;
      data_pend <= data_rd;
      // Only consecutive losses count; any cycle inst is idle or served restarts the count.
      if (bus.inst_req && !inst_gnt) begin
        if (!starved) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign bus.inst_gnt    = inst_gnt;
  assign bus.data_gnt    = data_gnt;
  assign bus.mem_en      = inst_gnt | data_gnt;
  assign bus.mem_wen     = mux_wen;
  assign bus.mem_addr    = mux_addr;
  assign bus.mem_wdata   = mux_wdata;
  assign bus.inst_rvalid = inst_pend;
  assign bus.data_rvalid = data_pend;
  assign bus.inst_rdata  = bus.mem_rdata;
  assign bus.data_rdata  = bus.mem_rdata;

  a_one_grant: assert property (@(posedge clk) disable iff (!resetn) !(inst_gnt && data_gnt));
  a_one_reader: assert property (@(posedge clk) disable iff (!resetn) !(inst_pend && data_pend));
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, SRAM-like memory between the CPU's instruction-fetch requester and its data-access requester. Sits between the pipeline's IF/EXE memory interfaces and a unified RAM port. Uses fixed data-over-instruction priority with a bounded-starvation override. Completes one access per cycle and returns read data one cycle after grant, matching the synchronous-read timing the pipeline already expects from its SRAMs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- MAX_WAIT, 4, max consecutive contended cycles inst may lose; legal range ≥1
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  instruction read request (read-only requester)
- inst_addr  in  ADDR_W  instruction address
- inst_gnt  out  1  inst access issued to memory this cycle
- inst_rvalid  out  1  inst_rdata valid (one cycle after inst_gnt)
- inst_rdata  out  DATA_W  read data to inst requester
- data_req  in  1  data request
- data_wen  in  DATA_W/8  byte write strobes; all-zero = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_gnt  out  1  data access issued to memory this cycle
- data_rvalid  out  1  data_rdata valid (one cycle after a data read grant)
- data_rdata  out  DATA_W  read data to data requester
- mem_en  out  1  memory enable
- mem_wen  out  DATA_W/8  memory byte write strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_wen=0

## Operation
- State:
  - starve_cnt: saturating counter, width clog2(MAX_WAIT+1).
  - inst_pend, data_pend: registered read-owner flags.
- Grant decision (combinational, same cycle as the request):
  - Neither req: no grant, mem_en=0.
  - One req: grant it.
  - Both req: grant inst if starve_cnt==MAX_WAIT, else grant data.
- Mux:
  - On an inst grant: mem_addr=inst_addr, mem_wen=0, mem_wdata=0.
  - On a data grant: mem_* driven from data_*.
  - With no grant: mem_addr, mem_wen and mem_wdata are 0.
  - mem_en = inst_gnt | data_gnt. The two grants are never both 1.
- starve_cnt update:
  - inst_req & ~inst_gnt: increment, saturating at MAX_WAIT.
  - Otherwise (granted, or not requesting): clear to 0.
- Read tracking:
  - inst_pend <= inst_gnt.
  - data_pend <= data_gnt & (data_wen==0).
  - inst_rvalid=inst_pend and data_rvalid=data_pend.
  - inst_rdata and data_rdata both equal mem_rdata; each is qualified only by its own rvalid.
- Writes: complete at grant. No rvalid is generated for a write.
- Requesters hold req/addr/wen/wdata stable until they see gnt. The arbiter does not latch request fields.
- Reset: resetn low clears starve_cnt, inst_pend and data_pend asynchronously. While resetn is low, inst_gnt, data_gnt and mem_en are forced to 0, and mem_wen=0.

## Timing
- Grant latency: 0 cycles for an uncontended request.
- Throughput: one access per cycle, back-to-back, with any mix of requesters.
- Read data latency: rvalid exactly 1 cycle after gnt. A new grant in that same cycle is permitted.
- Worst-case inst wait under continuous data contention: MAX_WAIT cycles. Inst is granted on cycle MAX_WAIT+1 (counting from 1).
- Reset values: all outputs 0; starve_cnt=0; both pend flags 0.
- Boundary conditions:
  - Reset asserted the cycle after a read grant: that rvalid drops immediately and the read is discarded.
  - Simultaneous inst grant and data write in the same cycle is impossible by construction.
  - inst_req dropping while starved clears starve_cnt.
  - data_req with data_wen≠0 at saturation still loses to inst.

## Test plan
- Reset: resetn=0 with both reqs high -> all gnt, mem_en, mem_wen and rvalid are 0. Release with no reqs -> mem_en stays 0.
- Inst-only read of 0xBFC00000 -> inst_gnt=1 same cycle, mem_addr=0xBFC00000, mem_wen=0. Next cycle inst_rvalid=1 with inst_rdata=mem_rdata (0x3C1DBFC0); data_rvalid=0.
- Data write (wen=4'hF, addr 0x00000100, wdata 0x12345678) contending with inst_req -> data_gnt=1, inst_gnt=0, mem_wdata=0x12345678. Next cycle data_rvalid=0 and starve_cnt=1.
- Starvation, MAX_WAIT=4, both reqs held high for 7 cycles -> data granted cycles 0–3, inst cycle 4, data cycle 5. starve_cnt reads 0,1,2,3,4,0,1 over cycles 0–6.
- Alternating single-cycle reads (data 0x200, inst 0x4, data 0x204) -> rvalid goes to data, inst, data in successive cycles, each carrying the mem_rdata of that cycle.
- Reset pulse one cycle after a data read grant -> data_rvalid=0 during reset and stays 0 after release with no reqs.
